// File: rtl/mem_bus_pkg.sv
// Shared types and default sizes for the Mini-SRC RAM initiator.
package mem_bus_pkg;

   localparam int DEFAULT_ADDR_W  = 9;
   localparam int DEFAULT_DATA_W  = 32;
   localparam int DEFAULT_BURST_W = 4;
   localparam int RAM_DEPTH       = 512;

   typedef enum logic [2:0] {
      IDLE,
      WR,
      RD_ISSUE,
      RD_DRAIN,
      DONE
   } state_t;

endpackage

// File: rtl/mem_rd_capture.sv
// Aligns the RAM's one-cycle read latency: registers the issue flag, then
// captures the returned word into rdata with a one-cycle rvalid pulse.
module mem_rd_capture #(
   parameter int DATA_W = 32
) (
   input  logic              clock,
   input  logic              clear_n,
   input  logic              issue,
   input  logic [DATA_W-1:0] ram_data_out,
   output logic [DATA_W-1:0] rdata,
   output logic              rvalid
);

   logic iss;

   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         iss    <= 1'b0;
         rdata  <= '0;
         rvalid <= 1'b0;
      end else begin
         iss <= issue;
         if (iss) begin
            rdata  <= ram_data_out;
            rvalid <= 1'b1;
         end else begin
            rvalid <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/mem_bus_master.sv
// Initiator for the 512 x 32 synchronous RAM: single write, single read and
// incrementing burst read behind a four-phase req/ack handshake.
//
// Handshake: req is a level held high until ack is seen; ack stays high until
// req falls, and the block returns to IDLE only after req has been seen low.
module mem_bus_master
   import mem_bus_pkg::*;
#(
   parameter int ADDR_W  = DEFAULT_ADDR_W,
   parameter int DATA_W  = DEFAULT_DATA_W,
   parameter int BURST_W = DEFAULT_BURST_W
) (
   input  logic               clock,
   input  logic               clear_n,
   input  logic               req,
   input  logic               we,
   input  logic [ADDR_W-1:0]  addr,
   input  logic [BURST_W-1:0] burst_len,
   input  logic [DATA_W-1:0]  wdata,
   output logic [DATA_W-1:0]  rdata,
   output logic               rvalid,
   output logic               ack,
   output logic               busy,
   output logic               ram_read,
   output logic               ram_write,
   output logic [ADDR_W-1:0]  ram_address,
   output logic [DATA_W-1:0]  ram_data_in,
   input  logic [DATA_W-1:0]  ram_data_out,
   output state_t             dbg_state
);

   localparam logic [ADDR_W-1:0]  ADDR_ONE = 1;
   localparam logic [BURST_W-1:0] CNT_ONE  = 1;

   state_t             state;
   state_t             state_nxt;
   logic [ADDR_W-1:0]  mar;
   logic [BURST_W-1:0] cnt;
   logic [DATA_W-1:0]  wreg;

   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         state <= IDLE;
         mar   <= '0;
         cnt   <= '0;
         wreg  <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (req) begin
                  mar  <= addr;
                  wreg <= wdata;
                  cnt  <= burst_len;
               end
            end
            // mar wraps naturally at the top of the RAM
            RD_ISSUE: begin
               mar <= mar + ADDR_ONE;
               cnt <= cnt - CNT_ONE;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nxt = state;
      ram_read  = 1'b0;
      ram_write = 1'b0;
      case (state)
         IDLE: begin
            if (req) state_nxt = we ? WR : RD_ISSUE;
         end
         WR: begin
            ram_write = 1'b1;
            state_nxt = DONE;
         end
         RD_ISSUE: begin
            ram_read = 1'b1;
            if (cnt == '0) state_nxt = RD_DRAIN;
         end
         RD_DRAIN: state_nxt = DONE;
         DONE: begin
            if (!req) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // RAM-side address and data come only from registers, never from req/addr.
   assign ram_address = mar;
   assign ram_data_in = wreg;
   assign ack         = (state == DONE);
   assign busy        = (state != IDLE);
   assign dbg_state   = state;

   mem_rd_capture #(
      .DATA_W (DATA_W)
   ) u_capture (
      .clock        (clock),
      .clear_n      (clear_n),
      .issue        (state == RD_ISSUE),
      .ram_data_out (ram_data_out),
      .rdata        (rdata),
      .rvalid       (rvalid)
   );

endmodule

// File: tb/tb_mem_bus_master.sv
// Randomized bench for mem_bus_master: behavioural RAM, reference memory,
// scoreboard of expected bus events and read words checked by a monitor.
module tb_mem_bus_master;
   import mem_bus_pkg::*;

   localparam int AW = 9;
   localparam int DW = 32;
   localparam int BW = 4;

   // clock / reset
   logic clock   = 1'b0;
   logic clear_n = 1'b1;
   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   logic          req = 1'b0;
   logic          we = 1'b0;
   logic [AW-1:0] addr = '0;
   logic [BW-1:0] burst_len = '0;
   logic [DW-1:0] wdata = '0;
   logic [DW-1:0] rdata;
   logic          rvalid, ack, busy, ram_read, ram_write;
   logic [AW-1:0] ram_address;
   logic [DW-1:0] ram_data_in;
   logic [DW-1:0] ram_data_out = '0;
   state_t        dbg_state;

   mem_bus_master #(.ADDR_W(AW), .DATA_W(DW), .BURST_W(BW)) dut (
      .clock        (clock),
      .clear_n      (clear_n),
      .req          (req),
      .we           (we),
      .addr         (addr),
      .burst_len    (burst_len),
      .wdata        (wdata),
      .rdata        (rdata),
      .rvalid       (rvalid),
      .ack          (ack),
      .busy         (busy),
      .ram_read     (ram_read),
      .ram_write    (ram_write),
      .ram_address  (ram_address),
      .ram_data_in  (ram_data_in),
      .ram_data_out (ram_data_out),
      .dbg_state    (dbg_state)
   );

   // behavioural synchronous RAM, one-cycle read latency
   logic [DW-1:0] mem [RAM_DEPTH];
   always @(posedge clock) begin
      if (ram_write === 1'b1) mem[ram_address] <= ram_data_in;
      if (ram_read === 1'b1) ram_data_out <= mem[ram_address];
   end

   // reference model and scoreboard
   logic [DW-1:0] ref_mem [RAM_DEPTH];
   typedef struct {
      int            cyc;
      bit            wr;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } bus_ev_t;
   bus_ev_t       bus_q[$];
   logic [DW-1:0] exp_q[$];
   int            exp_t_q[$];

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
      n_tests++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp_v, cyc);
      end
   endtask

   // driver: raise a request at a negedge while the DUT is in IDLE
   task automatic issue(input bit w, input logic [AW-1:0] a, input logic [BW-1:0] bl,
                        input logic [DW-1:0] d, output int t0, output int t_ack);
      logic [AW-1:0] aa;
      we = w; addr = a; burst_len = bl; wdata = d; req = 1'b1;
      t0 = cyc;
      if (w) begin
         bus_q.push_back('{t0 + 1, 1'b1, a, d});
         ref_mem[a] = d;
         t_ack = t0 + 2;
      end else begin
         for (int i = 0; i <= int'(bl); i++) begin
            aa = a + AW'(i);
            bus_q.push_back('{t0 + 1 + i, 1'b0, aa, '0});
            exp_q.push_back(ref_mem[aa]);
            exp_t_q.push_back(t0 + i + 3);
         end
         t_ack = t0 + int'(bl) + 3;
      end
   endtask

   task automatic scramble();
      we = 1'($urandom); addr = AW'($urandom); wdata = $urandom; burst_len = BW'($urandom);
   endtask

   task automatic run_txn(input bit w, input logic [AW-1:0] a, input logic [BW-1:0] bl,
                          input logic [DW-1:0] d, input int hold);
      int t0, t_ack, k;
      issue(w, a, bl, d, t0, t_ack);
      @(negedge clock);
      scramble();
      k = 1;
      while (ack !== 1'b1 && k < 40) begin
         @(negedge clock);
         k++;
      end
      if (ack !== 1'b1) chk("ack_timeout", ack, 1);
      else chk("ack_cycle", cyc, t_ack);
      repeat (hold) begin
         @(negedge clock);
         chk("ack_hold", {ack, busy, ram_read, ram_write}, 4'b1100);
         chk("state_done", dbg_state, DONE);
      end
      req = 1'b0;
      @(negedge clock);
      chk("ack_drop", {ack, busy}, 2'b00);
   endtask

   // monitor: pops expectations whenever the DUT drives the RAM or rvalid
   bus_ev_t ev;
   int      et;
   always @(negedge clock) begin
      if (clear_n) begin
         if (ram_read === 1'b1 || ram_write === 1'b1) begin
            if (bus_q.size() == 0) begin
               chk("bus_unexpected", {ram_write, ram_read}, 2'b00);
            end else begin
               ev = bus_q.pop_front();
               chk("bus_cycle", cyc, ev.cyc);
               chk("bus_kind", {ram_write, ram_read}, ev.wr ? 2'b10 : 2'b01);
               chk("bus_addr", ram_address, ev.a);
               if (ev.wr) chk("bus_wdata", ram_data_in, ev.d);
            end
         end
         if (rvalid === 1'b1) begin
            if (exp_q.size() == 0) begin
               chk("rvalid_unexpected", rvalid, 1'b0);
            end else begin
               et = exp_t_q.pop_front();
               chk("rdata", rdata, exp_q.pop_front());
               chk("rvalid_cycle", cyc, et);
            end
         end
      end
   end

   initial begin
      int t0, t_ack;
      logic [DW-1:0] v;
      for (int i = 0; i < RAM_DEPTH; i++) begin
         v = $urandom;
         mem[i] = v;
         ref_mem[i] = v;
      end
      for (int i = 0; i < 4; i++) begin
         mem['h10 + i] = 32'hA0 + i;
         ref_mem['h10 + i] = 32'hA0 + i;
      end

      // reset mid-cycle: outputs clear without a clock edge
      #3 clear_n = 1'b0;
      #1;
      chk("rst_outputs", {ack, busy, ram_read, ram_write, rvalid}, 5'b0);
      chk("rst_rdata", rdata, 0);
      chk("rst_addr", ram_address, 0);
      chk("rst_wdata", ram_data_in, 0);
      chk("rst_state", dbg_state, IDLE);
      repeat (2) @(negedge clock);
      #2 clear_n = 1'b1;
      repeat (8) begin
         @(negedge clock);
         chk("idle_quiet", {busy, ram_read, ram_write}, 3'b000);
      end

      // write then single read
      run_txn(1'b1, 9'h005, 4'd0, 32'hDEADBEEF, 0);
      run_txn(1'b0, 9'h005, 4'd0, '0, 0);
      // burst of four from preloaded words
      run_txn(1'b0, 9'h010, 4'd3, '0, 0);
      // burst wrapping past the top address
      run_txn(1'b0, 9'h1FF, 4'd2, '0, 0);
      // long ack hold, then back-to-back request
      run_txn(1'b1, 9'h040, 4'd5, $urandom, 5);
      run_txn(1'b0, 9'h040, 4'd0, '0, 0);

      // reset in the middle of an eight-word burst
      issue(1'b0, 9'h020, 4'd7, '0, t0, t_ack);
      @(negedge clock);
      scramble();
      repeat (2) @(negedge clock);
      chk("midrst_at_t3", cyc, t0 + 3);
      #2 clear_n = 1'b0;
      #1;
      chk("midrst_outputs", {ram_read, rvalid, busy, ack}, 4'b0000);
      bus_q.delete();
      exp_q.delete();
      exp_t_q.delete();
      req = 1'b0;
      repeat (2) @(negedge clock);
      #2 clear_n = 1'b1;
      repeat (10) begin
         @(negedge clock);
         chk("post_rst_quiet", {busy, rvalid, ram_read}, 3'b000);
      end
      run_txn(1'b0, 9'h020, 4'd0, '0, 0);

      // randomized traffic, biased toward the wrap region
      for (int n = 0; n < 40; n++) begin
         logic [AW-1:0] a;
         a = ($urandom_range(0, 3) == 0) ? AW'(9'h1F8 + $urandom_range(0, 7))
                                         : AW'($urandom_range(0, RAM_DEPTH - 1));
         run_txn(1'($urandom_range(0, 1)), a, BW'($urandom_range(0, 15)), $urandom,
                 $urandom_range(0, 3));
      end

      repeat (5) @(negedge clock);
      chk("bus_q_empty", bus_q.size(), 0);
      chk("exp_q_empty", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_bus_master.md
# mem_bus_master

Initiator side of the 512 x 32 synchronous RAM port, used by the Mini-SRC datapath. It accepts single read, single write and incrementing burst-read requests through a four-phase req/ack handshake. It drives the RAM's read, write, address and write-data lines, and captures the RAM's one-cycle-latency read data into a registered output. It sits between the CPU memory stage (MAR/MDR side) and the RAM.

## Interface
Parameters:
- ADDR_W, 9, RAM word-address width
- DATA_W, 32, data width
- BURST_W, 4, burst-length field width (max 16 words)

Ports:
- clock  in  1  sole clock; all state changes on the rising edge
- clear_n  in  1  reset, asynchronous, active-low
- req  in  1  request; level, held high until ack is seen
- we  in  1  1 = write, 0 = read; sampled with req in IDLE
- addr  in  ADDR_W  start word address; sampled in IDLE
- burst_len  in  BURST_W  number of words minus 1; reads only, ignored when we=1
- wdata  in  DATA_W  write data; sampled in IDLE
- rdata  out  DATA_W  captured read word; holds the last word until the next capture
- rvalid  out  1  one-cycle pulse per read word delivered
- ack  out  1  transaction complete; held high until req falls
- busy  out  1  high whenever state is not IDLE
- ram_read  out  1  RAM read enable
- ram_write  out  1  RAM write enable
- ram_address  out  ADDR_W  RAM address
- ram_data_in  out  DATA_W  RAM write data
- ram_data_out  in  DATA_W  RAM read data; valid in the cycle after the address edge

## Operation
- States:
  - IDLE: if req=1, latch addr into the internal address register (mar), wdata into wreg, burst_len into cnt. Go to WR if we=1, else RD_ISSUE.
  - WR: ram_write=1, ram_address=mar, ram_data_in=wreg. Go to DONE next cycle.
  - RD_ISSUE: ram_read=1, ram_address=mar. Each cycle, mar <= mar+1 (mod 2^ADDR_W, so 0x1FF wraps to 0x000) and cnt <= cnt-1. In the cycle with cnt=0, go to RD_DRAIN.
  - RD_DRAIN: one cycle, no RAM access. Go to DONE.
  - DONE: ack=1. Stay while req=1. Go to IDLE when req=0.
- Capture pipeline:
  - issue flag iss is registered from (state==RD_ISSUE).
  - When iss=1: rdata <= ram_data_out and rvalid <= 1. Otherwise rvalid <= 0.
- ram_read, ram_write and ram_address are decoded from registered state and mar only; no combinational path from req or addr.
- Outside WR and RD_ISSUE: ram_read=0, ram_write=0. ram_address holds mar.
- Reset (any cycle): state=IDLE, mar=0, cnt=0, wreg=0, iss=0, rdata=0, rvalid=0. Consequently ack=0, busy=0, ram_read=0, ram_write=0, ram_address=0, ram_data_in=0.
  - Reset during a burst abandons the burst; no further rvalid.
  - A RAM write already clocked at the same edge as reset assertion is not undone.

## Timing
- Request seen in IDLE cycle t0:
  - Write: ram_write high in t1 only; ack rises in t2.
  - Read of N = burst_len+1 words: addresses issued in t1..tN; word k is on rdata with rvalid=1 in cycle t(k+2); ack rises in t(N+2), the same cycle as the last rvalid.
  - Single read: rdata/rvalid/ack all in t3.
- Minimum spacing: ack rises in cycle T. The requester drops req, seen low in T+1. IDLE is in T+2, and the next request can be seen there.
- req low in IDLE: no activity. Changes to we, addr, wdata or burst_len outside IDLE have no effect.

## Structure
- Package mem_bus_pkg holds:
  - the state enum (IDLE, WR, RD_ISSUE, RD_DRAIN, DONE)
  - ADDR_W, DATA_W, BURST_W defaults
  - RAM_DEPTH = 512
- One sub-module: mem_rd_capture (iss flag, rdata/rvalid registers, async clear). Keeps the read-latency alignment separate from the FSM.

## Test plan
- Reset: clear_n low mid-cycle → all outputs 0 immediately. After release, idle with req=0 → ram_read=ram_write=0 and busy=0 indefinitely.
- Write then read: write addr=0x005, wdata=0xDEADBEEF → ram_write=1 with ram_address=0x005 in t1 only, ack in t2. Then read 0x005 → rdata=0xDEADBEEF, rvalid=1 and ack=1 in t3.
- Burst: RAM preloaded 0x010..0x013 = 0xA0..0xA3; read addr=0x010, burst_len=3 → rvalid high in t3..t6 with rdata 0xA0, 0xA1, 0xA2, 0xA3; ack in t6; ram_read high in t1..t4 exactly.
- Wrap: read addr=0x1FF, burst_len=2 → ram_address 0x1FF, 0x000, 0x001 in t1..t3; data returned in the same order.
- Four-phase: hold req high 5 cycles after ack → state stays DONE, ack stays 1, no RAM access. Drop req → ack=0 and busy=0 next cycle; a new request is accepted one cycle after that.
- Reset mid-burst: burst_len=7 from 0x020, clear_n low in t3 → ram_read, rvalid and busy fall immediately, no rvalid after release. A following single read of 0x020 returns the correct word in t3.
